serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the single byte-wide transmit port of `usb_serial` (`uart_tx_ready` / `uart_tx_strobe` / `uart_tx_data`) between two byte producers, for example the host-echo path and the status/debug character generator. Each producer gets a one-byte holding register and its own ready/strobe handshake. Arbitration is round-robin per byte. A producer may hold a lock to keep a multi-byte message contiguous, up to a bounded burst. The block sits between the producers and the USB serial TX FIFO in the 12 MHz `clk` domain.

## Interface
- `MAX_BURST`, default 16: maximum consecutive bytes a locked owner may send while the other source is waiting; 1..255.
- `clk` in 1: system clock (12 MHz domain).
- `reset` in 1: synchronous, active-high.
- `a_strobe` in 1: source A byte valid, one-cycle pulse.
- `a_data` in 8: source A byte.
- `a_lock` in 1: source A requests to keep the grant after its next byte.
- `a_ready` out 1: source A holding register empty.
- `a_overrun` out 1: one-cycle pulse; A strobed while full, byte dropped.
- `b_strobe`, `b_data`, `b_lock`, `b_ready`, `b_overrun`: same as the A ports, for source B.
- `tx_ready` in 1: downstream can accept a byte.
- `tx_strobe` out 1: registered one-cycle pulse with `tx_data`.
- `tx_data` out 8: registered byte, held until the next strobe.
- `last_grant` out 1: 0 = A, 1 = B; source that issued the most recent byte.
- `hold` out 1: high while the FSM is in HOLD.

## Operation
- **Holding registers**
  - `x_ready = !x_full`.
  - `x_strobe` with `!x_full` loads `x_data`; `x_full` is set at the next edge.
  - `x_strobe` with `x_full` keeps the old byte and pulses `x_overrun` on the next cycle.
  - Issuing a byte from `x` clears `x_full` at the same edge `tx_strobe` rises.
- **FSM states:** ARB, HOLD, GAP.
- **ARB**
  - If `tx_ready` and at least one source is full, issue one byte.
  - Only one full: issue that source.
  - Both full: issue `!last_grant`.
  - On issue: `tx_strobe` is 1 and `tx_data` is the byte for the next cycle; `last_grant` takes the issued source; go to GAP.
  - At the issue edge, sample the owner's lock into `lock_q`.
  - Burst counter: if owner == previous `last_grant`, `burst` increments, saturating at `MAX_BURST`; otherwise `burst` = 1.
- **GAP**
  - Exactly one cycle; `tx_strobe` is 0 and `tx_ready` is ignored.
  - Go to HOLD if `lock_q` is set and (`burst < MAX_BURST` or the other source is not full); otherwise go to ARB.
- **HOLD**
  - Only the `last_grant` source may issue, when it is full and `tx_ready`. Issue behaves as in ARB, then go to GAP.
  - Owner lock input low: go to ARB with no issue that cycle.
  - Other source full and `burst == MAX_BURST`: go to ARB. The other source then wins because it is `!last_grant`.
  - An owner that is locked but empty stalls the other source indefinitely until its lock drops or the burst limit applies.
- **Reset values:**
  - `tx_strobe` 0, `tx_data` 0.
  - `a_ready` / `b_ready` 1; holding registers empty.
  - `a_overrun` / `b_overrun` 0.
  - `last_grant` 1, so A wins the first tie.
  - `hold` 0, `burst` 0, `lock_q` 0; state ARB.
- **Reset mid-operation:** any byte held in a holding register is discarded, and `tx_strobe` is low on the cycle after reset is sampled.

## Timing
- **Latency:** strobe into an empty holding register at edge k, uncontended, `tx_ready` high gives `tx_strobe` high for cycle k+1..k+2. That is two edges from producer strobe to TX strobe.
- **Throughput:**
  - At most one byte every 2 cycles, so `tx_strobe` is never high on two consecutive cycles.
  - A producer may re-strobe in the cycle after its byte issues, because `x_ready` is already high then.
- **Downstream rule:** `tx_ready` is sampled only in ARB/HOLD; the cycle after a strobe (GAP) is never evaluated.
- **Overrun pulse:** `x_overrun` is high for exactly the cycle after the offending strobe.
- **Same-cycle drain and strobe:** since `x_ready` is low during the drain cycle, a strobe then counts as an overrun.

## Test plan
- **Reset defaults:** after reset, check `a_ready`=`b_ready`=1, `tx_strobe`=0, `tx_data`=0, `last_grant`=1.
- **Single byte latency:** A strobes 0x41 at edge k with `tx_ready`=1. Require `tx_strobe` for one cycle after edge k+1, `tx_data`=0x41, `last_grant`=0, `a_ready` low for exactly one cycle.
- **Round-robin:** A and B both full continuously, no locks. Require output A,B,A,B… with a strobe every 2 cycles and never two consecutive strobe cycles.
- **Lock and burst limit:** `MAX_BURST`=4, A locked with 10 bytes streaming, B full. Require 4 A bytes, then 1 B byte, then A resumes. With B empty, all 10 A bytes go out contiguously.
- **Lock release and `tx_ready` stall:** A locks, sends 0x10, then stays empty. B is full. Require no B byte while `a_lock`=1; after `a_lock` falls, B issues 2 cycles later. Holding `tx_ready`=0 for 20 cycles gives no strobes and no data loss.
- **Overrun and mid-operation reset:**
  - B strobes 0x55 then 0x66 on the next cycle while `tx_ready`=0. Require `b_overrun` to pulse once and 0x55 to be the byte later issued.
  - Reset asserted while a byte is held: the byte is never issued.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin two-source byte arbiter with lock/burst hold for usb_serial TX
module serial_tx_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_strobe,
  input  logic [7:0] a_data,
  input  logic       a_lock,
  output logic       a_ready,
  output logic       a_overrun,
  input  logic       b_strobe,
  input  logic [7:0] b_data,
  input  logic       b_lock,
  output logic       b_ready,
  output logic       b_overrun,
  input  logic       tx_ready,
  output logic       tx_strobe,
  output logic [7:0] tx_data,
  output logic       last_grant,
  output logic       hold
);

  typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_GAP} state_e;

  localparam logic [7:0] MAX_B = MAX_BURST[7:0];

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][7:0] data_q, data_d;
  logic [1:0]      ovr_q, ovr_d;
  logic            last_q, last_d;
  logic            lock_q, lock_d;
  logic [7:0]      burst_q, burst_d;
  logic            tx_strobe_q, tx_strobe_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic            issue;
  logic            issue_sel;
  logic [1:0]      strobe_in;
  logic [1:0]      lock_in;
  logic            owner_full, other_full, owner_lock;

  assign strobe_in  = {b_strobe, a_strobe};
  assign lock_in    = {b_lock, a_lock};
  assign owner_full = full_q[last_q];
  assign other_full = full_q[~last_q];
  assign owner_lock = lock_in[last_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the issue decision; GAP never looks at tx_ready.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_sel = last_q;
    case (state_q)
      ST_ARB: begin
        if (tx_ready && (full_q != 2'b00)) begin
          issue     = 1'b1;
          issue_sel = (full_q == 2'b11) ? ~last_q : full_q[1];
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = (lock_q && ((burst_q < MAX_B) || !other_full)) ? ST_HOLD : ST_ARB;
      end
      ST_HOLD: begin
        if (!owner_lock) begin
          state_d = ST_ARB;
        end else if (other_full && (burst_q == MAX_B)) begin
          state_d = ST_ARB;
        end else if (owner_full && tx_ready) begin
          issue     = 1'b1;
          issue_sel = last_q;
          state_d   = ST_GAP;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    hold       = (state_q == ST_HOLD);
    a_ready    = ~full_q[0];
    b_ready    = ~full_q[1];
    a_overrun  = ovr_q[0];
    b_overrun  = ovr_q[1];
    tx_strobe  = tx_strobe_q;
    tx_data    = tx_data_q;
    last_grant = last_q;
  end

  always_comb begin
    full_d      = full_q;
    data_d      = data_q;
    last_d      = last_q;
    lock_d      = lock_q;
    burst_d     = burst_q;
    tx_strobe_d = issue;
    tx_data_d   = tx_data_q;
    if (issue) begin
      tx_data_d         = data_q[issue_sel];
      full_d[issue_sel] = 1'b0;
      last_d            = issue_sel;
      lock_d            = lock_in[issue_sel];
      if (issue_sel == last_q) begin
        burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + 8'd1;
      end else begin
        burst_d = 8'd1;
      end
    end
    // A strobe into a full register (including the drain cycle) is dropped.
    ovr_d = strobe_in & full_q;
    if (a_strobe && !full_q[0]) begin
      full_d[0] = 1'b1;
      data_d[0] = a_data;
    end
    if (b_strobe && !full_q[1]) begin
      full_d[1] = 1'b1;
      data_d[1] = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= 2'b00;
      data_q      <= '0;
      ovr_q       <= 2'b00;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      burst_q     <= 8'd0;
      tx_strobe_q <= 1'b0;
      tx_data_q   <= 8'd0;
    end else begin
      full_q      <= full_d;
      data_q      <= data_d;
      ovr_q       <= ovr_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      burst_q     <= burst_d;
      tx_strobe_q <= tx_strobe_d;
      tx_data_q   <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_strobe = 1'b0, b_strobe = 1'b0;
  logic [7:0] a_data = 8'd0, b_data = 8'd0;
  logic       a_lock = 1'b0, b_lock = 1'b0;
  logic       a_ready, b_ready, a_overrun, b_overrun;
  logic       tx_ready = 1'b1;
  logic       tx_strobe;
  logic [7:0] tx_data;
  logic       last_grant, hold;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .a_strobe(a_strobe), .a_data(a_data), .a_lock(a_lock),
    .a_ready(a_ready), .a_overrun(a_overrun),
    .b_strobe(b_strobe), .b_data(b_data), .b_lock(b_lock),
    .b_ready(b_ready), .b_overrun(b_overrun),
    .tx_ready(tx_ready), .tx_strobe(tx_strobe), .tx_data(tx_data),
    .last_grant(last_grant), .hold(hold)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-source arrays, a pending-gap flag and a "held by owner" flag.
  bit         started = 1'b0;
  bit         m_full[2];
  logic [7:0] m_data[2];
  bit         m_last, m_lock, m_gap, m_hold;
  int         m_burst;
  bit         e_strobe;
  logic [7:0] e_data;
  bit         e_ovr[2];

  always @(posedge clk) begin
    bit         st[2];
    logic [7:0] dn[2];
    bit         lk[2];
    bit         was[2];
    int         iss;
    if (reset) begin
      started = 1'b1;
      for (int s = 0; s < 2; s++) begin
        m_full[s] = 1'b0; m_data[s] = 8'd0; e_ovr[s] = 1'b0;
      end
      m_last = 1'b1; m_lock = 1'b0; m_gap = 1'b0; m_hold = 1'b0;
      m_burst = 0; e_strobe = 1'b0; e_data = 8'd0;
    end else begin
      st[0] = a_strobe; st[1] = b_strobe;
      dn[0] = a_data;   dn[1] = b_data;
      lk[0] = a_lock;   lk[1] = b_lock;
      was[0] = m_full[0]; was[1] = m_full[1];
      iss = -1;
      if (m_gap) begin
        m_gap  = 1'b0;
        m_hold = m_lock && (m_burst < MB || !m_full[!m_last]);
      end else if (m_hold) begin
        if (!lk[m_last]) m_hold = 1'b0;
        else if (m_full[!m_last] && m_burst == MB) m_hold = 1'b0;
        else if (m_full[m_last] && tx_ready) iss = int'(m_last);
      end else if (tx_ready) begin
        if (m_full[0] && m_full[1]) iss = int'(!m_last);
        else if (m_full[0]) iss = 0;
        else if (m_full[1]) iss = 1;
      end
      e_strobe = 1'b0;
      if (iss >= 0) begin
        e_strobe = 1'b1;
        e_data   = m_data[iss];
        m_burst  = (iss == int'(m_last)) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
        m_last   = iss[0];
        m_lock   = lk[iss];
        m_gap    = 1'b1;
        m_hold   = 1'b0;
        m_full[iss] = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        e_ovr[s] = st[s] && was[s];
        if (st[s] && !was[s]) begin
          m_full[s] = 1'b1;
          m_data[s] = dn[s];
        end
      end
    end
  end

  logic [7:0] got[$];
  logic       prev_stb = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("tx_strobe", tx_strobe, e_strobe);
      chk("tx_data", tx_data, e_data);
      chk("last_grant", last_grant, m_last);
      chk("a_ready", a_ready, !m_full[0]);
      chk("b_ready", b_ready, !m_full[1]);
      chk("a_overrun", a_overrun, e_ovr[0]);
      chk("b_overrun", b_overrun, e_ovr[1]);
      chk("hold", hold, m_hold);
      chk("no_back_to_back", tx_strobe & prev_stb, 1'b0);
      prev_stb = tx_strobe;
      if (tx_strobe === 1'b1) got.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_strobe = 1'b0; b_strobe = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  logic [7:0] exp_q[$];
  int na, nb;

  initial begin
    // Reset defaults
    reset = 1'b1;
    tick(); tick();
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_b_ready", b_ready, 1'b1);
    chk("rst_tx_strobe", tx_strobe, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_last_grant", last_grant, 1'b1);
    reset = 1'b0;
    tick();

    // Single byte latency
    a_strobe = 1'b1; a_data = 8'h41;
    tick();
    a_strobe = 1'b0;
    chk("lat_a_ready_low", a_ready, 1'b0);
    chk("lat_no_strobe_yet", tx_strobe, 1'b0);
    tick();
    chk("lat_strobe", tx_strobe, 1'b1);
    chk("lat_data", tx_data, 8'h41);
    chk("lat_grant", last_grant, 1'b0);
    chk("lat_a_ready_back", a_ready, 1'b1);
    tick();
    chk("lat_strobe_one_cycle", tx_strobe, 1'b0);

    // Round-robin with both sources kept full
    got.delete(); na = 0; nb = 0;
    for (int c = 0; c < 30; c++) begin
      a_strobe = a_ready && na < 4;
      if (a_strobe) begin a_data = 8'(8'hA0 + na); na++; end
      b_strobe = b_ready && nb < 4;
      if (b_strobe) begin b_data = 8'(8'hB0 + nb); nb++; end
      tick();
    end
    a_strobe = 1'b0; b_strobe = 1'b0;
    exp_q = '{8'hB0, 8'hA0, 8'hB1, 8'hA1, 8'hB2, 8'hA2, 8'hB3, 8'hA3};
    check_seq("rr_seq", exp_q);

    // Lock with burst limit while B waits
    do_reset();
    got.delete(); na = 0;
    a_lock = 1'b1;
    for (int c = 0; c < 60; c++) begin
      a_strobe = a_ready && na < 10;
      if (a_strobe) begin a_data = 8'(na); na++; end
      b_strobe = (c == 0);
      b_data = 8'hC0;
      tick();
    end
    a_strobe = 1'b0; b_strobe = 1'b0; a_lock = 1'b0;
    tick(); tick();
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hC0, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    check_seq("burst_seq", exp_q);

    // Lock with B empty: all ten contiguous
    do_reset();
    got.delete(); na = 0;
    a_lock = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a_strobe = a_ready && na < 10;
      if (a_strobe) begin a_data = 8'(8'h10 + na); na++; end
      tick();
    end
    a_strobe = 1'b0; a_lock = 1'b0;
    tick(); tick();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_seq("contig_seq", exp_q);

    // Lock release and tx_ready stall
    do_reset();
    got.delete();
    a_lock = 1'b1; a_strobe = 1'b1; a_data = 8'h10;
    b_strobe = 1'b1; b_data = 8'h20;
    tick();
    a_strobe = 1'b0; b_strobe = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("lock_only_a", got.size(), 1);
    chk("lock_hold", hold, 1'b1);
    a_lock = 1'b0;
    tick();
    chk("release_wait", tx_strobe, 1'b0);
    tick();
    chk("release_b_strobe", tx_strobe, 1'b1);
    chk("release_b_data", tx_data, 8'h20);
    tick();
    tx_ready = 1'b0;
    a_strobe = 1'b1; a_data = 8'h31; b_strobe = 1'b1; b_data = 8'h32;
    tick();
    a_strobe = 1'b0; b_strobe = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("stall_no_strobe", got.size(), 2);
    tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    exp_q = '{8'h10, 8'h20, 8'h31, 8'h32};
    check_seq("release_seq", exp_q);

    // Overrun
    got.delete();
    tx_ready = 1'b0;
    b_strobe = 1'b1; b_data = 8'h55;
    tick();
    b_data = 8'h66;
    tick();
    b_strobe = 1'b0;
    chk("ovr_pulse", b_overrun, 1'b1);
    tick();
    chk("ovr_single", b_overrun, 1'b0);
    tx_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    exp_q = '{8'h55};
    check_seq("ovr_seq", exp_q);

    // Reset while a byte is held
    got.delete();
    tx_ready = 1'b0;
    a_strobe = 1'b1; a_data = 8'h77;
    tick();
    a_strobe = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_a_ready", a_ready, 1'b1);
    chk("midrst_tx_strobe", tx_strobe, 1'b0);
    tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("midrst_dropped", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
